// File: rtl/skid_buffer_if.sv
// One valid/ready stream channel. The buffer takes the upstream channel as
// slave and drives the downstream channel as master.
interface skid_buffer_if #(
    parameter int DW = 24
);
    logic          valid;
    logic          ready;
    logic [DW-1:0] data;

    modport master (output valid, output data, input ready);
    modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/skid_buffer.sv
// Two-entry valid/ready register slice. m_valid, m_data and s_ready all come
// straight from flops, so no input reaches an output combinationally.
//
// state | meaning
// EMPTY | no beat held; m_valid=0, s_ready=1 once out of reset
// BUSY  | main register holds a beat; m_valid=1, s_ready=1
// FULL  | main and skid registers both hold beats; m_valid=1, s_ready=0
module skid_buffer #(
    parameter int            DW      = 24,
    parameter logic [DW-1:0] RST_VAL = '0
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clr,
    skid_buffer_if.slave  s,
    skid_buffer_if.master m
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_t;

    state_t        state_q;
    state_t        state_d;
    logic          rdy_en_q;
    logic [DW-1:0] main_q;
    logic [DW-1:0] skid_q;

    logic up_xfer;
    logic main_ld;
    logic main_from_skid;
    logic skid_ld;
    logic s_ready_o;
    logic m_valid_o;

    // rdy_en_q keeps s_ready low until the first edge after reset release
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= EMPTY;
            rdy_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            rdy_en_q <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else if (clr) begin
            main_q <= RST_VAL;
            skid_q <= RST_VAL;
        end else begin
            if (main_ld) main_q <= main_from_skid ? skid_q : s.data;
            if (skid_ld) skid_q <= s.data;
        end
    end

    assign up_xfer = s.valid & s_ready_o;

    always_comb begin
        state_d        = state_q;
        main_ld        = 1'b0;
        main_from_skid = 1'b0;
        skid_ld        = 1'b0;
        case (state_q)
            EMPTY: begin
                if (up_xfer) begin
                    main_ld = 1'b1;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                if (up_xfer && m.ready) begin
                    main_ld = 1'b1;
                end else if (up_xfer) begin
                    skid_ld = 1'b1;
                    state_d = FULL;
                end else if (m.ready) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (m.ready) begin
                    main_ld        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        // flush wins over any transfer; an upstream beat in this cycle is lost
        if (clr) begin
            state_d        = EMPTY;
            main_ld        = 1'b0;
            main_from_skid = 1'b0;
            skid_ld        = 1'b0;
        end
    end

    always_comb begin
        m_valid_o = (state_q == BUSY) || (state_q == FULL);
        s_ready_o = rdy_en_q && (state_q != FULL);
    end

    assign s.ready = s_ready_o;
    assign m.valid = m_valid_o;
    assign m.data  = main_q;

endmodule

// File: tb/tb_skid_buffer.sv
// Directed and random checks of skid_buffer against a two-entry FIFO model.
module tb_skid_buffer;

    localparam int DW = 24;

    logic clk;
    logic rst_n;
    logic clr;

    skid_buffer_if #(.DW(DW)) s_if ();
    skid_buffer_if #(.DW(DW)) m_if ();

    skid_buffer #(.DW(DW), .RST_VAL('0)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clr),
        .s     (s_if),
        .m     (m_if)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int            n_chk = 0;
    int            n_err = 0;
    int            n_in  = 0;
    int            n_out = 0;
    logic [DW-1:0] q[$];
    logic [DW-1:0] dlv[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance one edge and update the FIFO model from the handshakes seen before it.
    task automatic cycle();
        logic          up;
        logic          dn;
        logic [DW-1:0] din;
        logic [DW-1:0] dout;
        up   = s_if.valid & s_if.ready;
        dn   = m_if.valid & m_if.ready;
        din  = s_if.data;
        dout = m_if.data;
        @(posedge clk);
        #1;
        if (dn) begin
            dlv.push_back(dout);
            n_out++;
            if (q.size() > 0) void'(q.pop_front());
        end
        if (clr) q.delete();
        else if (up) begin
            q.push_back(din);
            n_in++;
        end
    endtask

    task automatic check_outputs(input string tag);
        chk({tag, "_m_valid"}, 32'(m_if.valid), 32'(q.size() > 0));
        chk({tag, "_s_ready"}, 32'(s_if.ready), 32'(q.size() < 2));
        if (q.size() > 0) chk({tag, "_m_data"}, 32'(m_if.data), 32'(q[0]));
    endtask

    task automatic step(input string tag);
        cycle();
        check_outputs(tag);
    endtask

    int            vcnt;
    int            ncyc;
    logic [DW-1:0] exp_bp[3];

    initial begin
        rst_n      = 1'b0;
        clr        = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = 24'h123456;
        m_if.ready = 1'b0;

        // 1: reset holds everything low even with s_valid asserted
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("rst_s_ready", 32'(s_if.ready), 32'd0);
            chk("rst_m_valid", 32'(m_if.valid), 32'd0);
            chk("rst_m_data", 32'(m_if.data), 32'd0);
        end
        #2 rst_n = 1'b1;
        #1;
        chk("rel_s_ready_pre", 32'(s_if.ready), 32'd0);
        cycle();
        chk("rel_s_ready", 32'(s_if.ready), 32'd1);
        chk("rel_m_valid", 32'(m_if.valid), 32'd0);
        s_if.valid = 1'b0;
        step("idle");

        // 2: back-to-back streaming
        m_if.ready = 1'b1;
        vcnt = 0;
        for (int i = 1; i <= 16; i++) begin
            s_if.valid = 1'b1;
            s_if.data  = DW'(i);
            step("stream");
            chk("stream_m_data_seq", 32'(m_if.data), i);
            if (m_if.valid) vcnt++;
        end
        s_if.valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step("stream_tail");
            if (m_if.valid) vcnt++;
        end
        chk("stream_valid_cycles", 32'(vcnt), 32'd16);

        // 3: backpressure with three beats offered
        dlv.delete();
        m_if.ready = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = 24'h0000A1;
        step("bp1");
        s_if.data  = 24'h0000A2;
        step("bp2");
        chk("bp_full_s_ready", 32'(s_if.ready), 32'd0);
        s_if.data  = 24'h0000A3;
        step("bp3");
        chk("bp_a3_not_taken", 32'(n_in), 32'd18);
        chk("bp_main_a1", 32'(m_if.data), 32'h0000A1);
        m_if.ready = 1'b1;
        step("bp_drain1");
        chk("bp_s_ready_back", 32'(s_if.ready), 32'd1);
        step("bp_drain2");
        s_if.valid = 1'b0;
        step("bp_drain3");
        step("bp_drain4");
        exp_bp[0] = 24'h0000A1;
        exp_bp[1] = 24'h0000A2;
        exp_bp[2] = 24'h0000A3;
        chk("bp_dlv_count", 32'(dlv.size()), 32'd3);
        for (int i = 0; i < 3 && i < dlv.size(); i++)
            chk("bp_order", 32'(dlv[i]), 32'(exp_bp[i]));

        // 4: random valid/ready, model checks order, stability and s_ready
        n_in  = 0;
        n_out = 0;
        ncyc  = 0;
        while (n_out < 10000 && ncyc < 60000) begin
            s_if.valid = (n_in < 10000) ? 1'($urandom_range(0, 1)) : 1'b0;
            s_if.data  = DW'($urandom_range(0, 24'hFFFFFF));
            m_if.ready = 1'($urandom_range(0, 1));
            step("rand");
            ncyc++;
        end
        chk("rand_beats_in", 32'(n_in), 32'd10000);
        chk("rand_beats_out", 32'(n_out), 32'd10000);
        s_if.valid = 1'b0;
        m_if.ready = 1'b1;
        step("rand_idle");

        // 5: clr while FULL, both sides handshaking
        m_if.ready = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = 24'h0000B1;
        step("clr_fill1");
        s_if.data  = 24'h0000B2;
        step("clr_fill2");
        chk("clr_pre_s_ready", 32'(s_if.ready), 32'd0);
        dlv.delete();
        s_if.data  = 24'h0000B3;
        m_if.ready = 1'b1;
        clr        = 1'b1;
        cycle();
        clr        = 1'b0;
        s_if.valid = 1'b0;
        chk("clr_m_valid", 32'(m_if.valid), 32'd0);
        chk("clr_s_ready", 32'(s_if.ready), 32'd1);
        chk("clr_m_data", 32'(m_if.data), 32'd0);
        chk("clr_delivered", 32'(dlv.size()), 32'd1);
        if (dlv.size() > 0) chk("clr_delivered_val", 32'(dlv[0]), 32'h0000B1);
        step("clr_after");
        step("clr_after2");

        // 6: async reset between edges while FULL
        m_if.ready = 1'b0;
        s_if.valid = 1'b1;
        s_if.data  = 24'h0000C1;
        step("ar_fill1");
        s_if.data  = 24'h0000C2;
        step("ar_fill2");
        s_if.valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        q.delete();
        chk("ar_m_valid", 32'(m_if.valid), 32'd0);
        chk("ar_s_ready", 32'(s_if.ready), 32'd0);
        chk("ar_m_data", 32'(m_if.data), 32'd0);
        @(posedge clk);
        #3 rst_n = 1'b1;
        s_if.valid = 1'b1;
        s_if.data  = 24'h00005A;
        m_if.ready = 1'b1;
        cycle();
        chk("ar_rel_s_ready", 32'(s_if.ready), 32'd1);
        chk("ar_rel_m_valid", 32'(m_if.valid), 32'd0);
        cycle();
        s_if.valid = 1'b0;
        chk("ar_5a_m_valid", 32'(m_if.valid), 32'd1);
        chk("ar_5a_m_data", 32'(m_if.data), 32'h00005A);
        step("ar_end");

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
